led7seg_bus_reader: RTL and testbench
=====================================

// Module: led7seg_bus_reader
// PURPOSE
//  Receiving end of the multiplexed 7-segment display bus. Samples segment lines and one-hot
//  digit select driven by an external display scanner, waits for a stable pattern, and
//  converts each digit's segment pattern back to a hex nibble plus decimal point.
//  Sits between the display bus pins and the self-test/monitor logic; per-digit change
//  events go out on a valid/ready stream.
// PARAMETERS
//  DIGITS         4   number of multiplexed digits (width of dig_sel), 1..8
//  STABLE_CYCLES  4   consecutive identical synchronised samples required before capture, >=1
// PORTS
//  clk          in   1          system clock, all state on rising edge
//  rst_n        in   1          asynchronous active-low reset
//  seg_in       in   8          segment lines {a,b,c,d,e,f,g,dp}, bit7=a, bit0=dp, 1=lit
//  dig_sel      in   DIGITS     digit enable, one-hot, 1=active
//  digits_out   out  4*DIGITS   decoded nibble per digit, digit i at [4i+3:4i]
//  dp_out       out  DIGITS     captured decimal point per digit
//  valid_out    out  DIGITS     1 = digit i holds a legal decoded pattern
//  upd_valid    out  1          change event pending
//  upd_ready    in   1          consumer accepts event
//  upd_idx      out  3          digit index of event
//  upd_nibble   out  4          nibble of event
//  upd_dp       out  1          dp of event
//  err_invalid  out  1          sticky: illegal pattern captured
//  upd_ovf      out  1          sticky: event dropped while one was pending
//  err_clr      in   1          synchronous clear of err_invalid and upd_ovf
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, sync flops 0, counter 0, FSM IDLE. Mid-operation reset
//    discards any pending event and all captured digits.
//  - seg_in/dig_sel pass through a 2-flop synchroniser; s = synchronised {dig_sel,seg_in}.
//  - FSM: IDLE -> SETTLE when s != previous s (cnt<=0). SETTLE: s == prev -> cnt++; s != prev ->
//    cnt<=0, stay. SETTLE -> HELD on capture. HELD: s != prev -> SETTLE (cnt<=0). One capture per
//    stable window.
//  - Capture when s has held equal for STABLE_CYCLES edges: inputs constant from edge k ->
//    digits_out/valid_out/upd_valid update at edge k+2+STABLE_CYCLES.
//  - dig_sel zero or multi-hot at capture: no capture action, FSM still enters HELD.
//  - Decode on seg[7:1] (dp ignored): 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:72 8:7F 9:7B
//    A:77 B:1F C:0D D:3D E:4F F:47 (hex of seg[7:1]).
//    Match -> digits_out[i]=nibble, dp_out[i]=seg[0], valid_out[i]=1.
//    seg[7:1]=0 (blank) -> valid_out[i]=0, no error.
//    Other -> valid_out[i]=0, err_invalid<=1.
//  - Event raised on match when valid_out[i] was 0 or nibble/dp differs from stored. No event for blank/illegal.
//  - Handshake: payload stable while upd_valid=1 && !upd_ready; transfer on edge with both high.
//    New event with pending unaccepted event: new one dropped, upd_ovf<=1.
//    New event on same edge as transfer: new event loaded, upd_valid stays 1.
//  - err_clr: clears both stickies; a set condition on the same edge wins.
// CONFIGURATION
//  LED7SEG_READER_ACTIVE_LOW_EN defined: seg_in and dig_sel inverted after the synchroniser
//    (common-anode bus, 0=lit/selected). Reset value of sync flops becomes all-ones, so reset
//    reads as "nothing lit".
//  Undefined: active-high bus as specified above.
// TESTING (DIGITS=4, STABLE_CYCLES=4)
//  1. dig_sel=0001, seg_in=8'hFC held from edge 0 -> edge 6: digits_out[3:0]=0, valid_out=0001,
//     upd_valid=1, upd_idx=0, upd_nibble=0.
//  2. Scan digits 0..3 with 8'h60,8'hDA,8'hF3,8'h66, 10 cycles each, upd_ready=1 ->
//     digits_out=16'h4321, dp_out=0100, four events in order, no repeat on 2nd scan.
//  3. seg_in toggles 8'h60/8'hDA every 3 cycles -> no capture, upd_valid=0, valid_out unchanged.
//  4. seg_in=8'h02 captured -> err_invalid=1, valid_out[i]=0; err_clr pulse -> err_invalid=0.
//  5. upd_ready=0, two distinct captures -> first payload held, upd_ovf=1;
//     raise upd_ready -> first event transferred.
//  6. rst_n low mid-SETTLE with event pending -> all outputs 0 immediately (no clock edge needed).

Source files
------------

// File: rtl/led7seg_bus_reader_if.sv
// Change-event stream from the 7-segment bus reader to its consumer.
// The master drives the payload and valid, and the slave drives ready.
interface led7seg_bus_reader_if;
  logic       upd_valid;
  logic       upd_ready;
  logic [2:0] upd_idx;
  logic [3:0] upd_nibble;
  logic       upd_dp;

  modport master (
    output upd_valid,
    output upd_idx,
    output upd_nibble,
    output upd_dp,
    input  upd_ready
  );

  modport slave (
    input  upd_valid,
    input  upd_idx,
    input  upd_nibble,
    input  upd_dp,
    output upd_ready
  );
endinterface

// File: rtl/led7seg_bus_reader.sv
// Receiving end of a multiplexed 7-segment bus. It synchronises the bus and waits for a stable
// pattern. It then decodes each digit to hex and emits change events. Define
// LED7SEG_READER_ACTIVE_LOW_EN for a common-anode (0 = lit/selected) bus.
module led7seg_bus_reader #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             seg_in,
  input  logic [DIGITS-1:0]      dig_sel,
  output logic [4*DIGITS-1:0]    digits_out,
  output logic [DIGITS-1:0]      dp_out,
  output logic [DIGITS-1:0]      valid_out,
  led7seg_bus_reader_if.master   upd,
  output logic                   err_invalid,
  output logic                   upd_ovf,
  input  logic                   err_clr
);

  localparam int unsigned SW   = DIGITS + 8;
  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

  logic [SW-1:0]     sync1_q, sync2_q, s, prev_q;
  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [7:0]        seg_s;
  logic [DIGITS-1:0] sel_s;
  logic              changed, capture, sel_ok, dec_match, dec_blank, new_event, busy;
  logic [3:0]        dec_nib, cur_nib;
  logic              cur_dp, cur_valid;
  logic [2:0]        sel_idx;

`ifdef LED7SEG_READER_ACTIVE_LOW_EN
  // Resetting the flops to all-ones makes the inverted view read as an idle bus.
  localparam logic [SW-1:0] SyncRst = '1;
  assign s = ~sync2_q;
`else
  localparam logic [SW-1:0] SyncRst = '0;
  assign s = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= SyncRst;
      sync2_q <= SyncRst;
    end else begin
      sync1_q <= {dig_sel, seg_in};
      sync2_q <= sync1_q;
    end
  end

  assign seg_s     = s[7:0];
  assign sel_s     = s[SW-1:8];
  assign changed   = (s != prev_q);
  assign capture   = (state_q == StSettle) && !changed && (cnt_q == CntW'(STABLE_CYCLES - 1));
  assign sel_ok    = $onehot(sel_s);
  assign dec_blank = (seg_s[7:1] == 7'h00);
  assign busy      = upd.upd_valid && !upd.upd_ready;
  assign new_event = capture && sel_ok && dec_match &&
                     (!cur_valid || (cur_nib != dec_nib) || (cur_dp != seg_s[0]));

  always_comb begin
    dec_match = 1'b1;
    dec_nib   = 4'h0;
    case (seg_s[7:1])
      7'h7E:   dec_nib = 4'h0;
      7'h30:   dec_nib = 4'h1;
      7'h6D:   dec_nib = 4'h2;
      7'h79:   dec_nib = 4'h3;
      7'h33:   dec_nib = 4'h4;
      7'h5B:   dec_nib = 4'h5;
      7'h5F:   dec_nib = 4'h6;
      7'h72:   dec_nib = 4'h7;
      7'h7F:   dec_nib = 4'h8;
      7'h7B:   dec_nib = 4'h9;
      7'h77:   dec_nib = 4'hA;
      7'h1F:   dec_nib = 4'hB;
      7'h0D:   dec_nib = 4'hC;
      7'h3D:   dec_nib = 4'hD;
      7'h4F:   dec_nib = 4'hE;
      7'h47:   dec_nib = 4'hF;
      default: dec_match = 1'b0;
    endcase
    sel_idx   = '0;
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_valid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_s[i]) begin
        sel_idx   = 3'(i);
        cur_nib   = digits_out[4*i +: 4];
        cur_dp    = dp_out[i];
        cur_valid = valid_out[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      prev_q         <= '0;
      digits_out     <= '0;
      dp_out         <= '0;
      valid_out      <= '0;
      upd.upd_valid  <= 1'b0;
      upd.upd_idx    <= '0;
      upd.upd_nibble <= '0;
      upd.upd_dp     <= 1'b0;
      err_invalid    <= 1'b0;
      upd_ovf        <= 1'b0;
    end else begin
      prev_q <= s;
      case (state_q)
        StIdle: begin
          if (changed) begin
            state_q <= StSettle;
            cnt_q   <= '0;
          end
        end
        StSettle: begin
          if (changed) begin
            cnt_q <= '0;
          end else if (capture) begin
            state_q <= StHeld;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StHeld: begin
          if (changed) begin
            state_q <= StSettle;
            cnt_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Zero or multi-hot select still closes the window, but it leaves the digits untouched.
      if (capture && sel_ok) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (sel_s[i]) begin
            if (dec_match) begin
              digits_out[4*i +: 4] <= dec_nib;
              dp_out[i]            <= seg_s[0];
              valid_out[i]         <= 1'b1;
            end else begin
              valid_out[i] <= 1'b0;
            end
          end
        end
      end

      if (err_clr) begin
        err_invalid <= 1'b0;
        upd_ovf     <= 1'b0;
      end
      if (capture && sel_ok && !dec_match && !dec_blank) begin
        err_invalid <= 1'b1;
      end

      if (new_event && busy) begin
        upd_ovf <= 1'b1;
      end else if (new_event) begin
        upd.upd_valid  <= 1'b1;
        upd.upd_idx    <= sel_idx;
        upd.upd_nibble <= dec_nib;
        upd.upd_dp     <= seg_s[0];
      end else if (upd.upd_valid && upd.upd_ready) begin
        upd.upd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_led7seg_bus_reader.sv
// Directed and random stimulus for led7seg_bus_reader (DIGITS=4, STABLE_CYCLES=4). Each cycle is
// checked against a run-length reference model of the bus reader.
module tb_led7seg_bus_reader;
  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  seg_r;
  logic [3:0]  sel_r;
  logic        clr;
  logic [15:0] digits_out;
  logic [3:0]  dp_out, valid_out;
  logic        err_invalid, upd_ovf;

  led7seg_bus_reader_if bus ();

  led7seg_bus_reader #(
    .DIGITS       (4),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_r),
    .dig_sel    (sel_r),
    .digits_out (digits_out),
    .dp_out     (dp_out),
    .valid_out  (valid_out),
    .upd        (bus),
    .err_invalid(err_invalid),
    .upd_ovf    (upd_ovf),
    .err_clr    (clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] tab7 [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h72,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h0D, 7'h3D, 7'h4F, 7'h47};

  // Reference model state
  logic [11:0] m_last, m_pipe0, m_pipe1;
  bit          m_pv0, m_pv1;
  int          m_run;
  logic [3:0]  m_dig [4];
  bit   [3:0]  m_dp, m_val;
  bit          m_err, m_ovf, m_uv, m_ud;
  logic [2:0]  m_ui;
  logic [3:0]  m_un;

  // Transfers seen on the DUT stream, as {idx, nibble, dp}
  logic [7:0]  dut_acc [$];
  bit          last_vld;
  logic [7:0]  last_pl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lookup(input logic [6:0] code);
    for (int n = 0; n < 16; n++) if (tab7[n] == code) return n;
    return -1;
  endfunction

  function automatic logic [7:0] ev(input int i, input int n, input int d);
    return {3'(i), 4'(n), 1'(d)};
  endfunction

  task automatic model_reset();
    m_last = '0; m_pipe0 = '0; m_pipe1 = '0; m_pv0 = 0; m_pv1 = 0;
    m_run = STABLE + 2;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
    m_dp = '0; m_val = '0; m_err = 0; m_ovf = 0; m_uv = 0; m_ud = 0; m_ui = '0; m_un = '0;
    last_vld = 0; last_pl = '0;
  endtask

  // A value sampled unchanged on STABLE+1 edges is committed two edges later.
  task automatic model_edge(input logic [3:0] sel, input logic [7:0] seg, input logic rdy,
                            input logic c);
    logic [11:0] cur, cv;
    bit          cap, new_ev, set_err;
    int          idx, n;
    cur = {sel, seg};
    cap = m_pv1;
    cv  = m_pipe1;
    m_pv1 = m_pv0;
    m_pipe1 = m_pipe0;
    if (cur == m_last) begin
      if (m_run < STABLE + 2) m_run++;
    end else begin
      m_run = 1;
    end
    m_last  = cur;
    m_pv0   = (m_run == STABLE + 1);
    m_pipe0 = cur;
    new_ev  = 0;
    set_err = 0;
    if (cap && $countones(cv[11:8]) == 1) begin
      idx = 0;
      for (int i = 0; i < 4; i++) if (cv[8+i]) idx = i;
      n = lookup(cv[7:1]);
      if (n >= 0) begin
        new_ev = !m_val[idx] || (m_dig[idx] != 4'(n)) || (m_dp[idx] != cv[0]);
        if (new_ev && !(m_uv && !rdy)) begin
          m_ui = 3'(idx); m_un = 4'(n); m_ud = cv[0];
        end
        m_dig[idx] = 4'(n); m_dp[idx] = cv[0]; m_val[idx] = 1;
      end else begin
        m_val[idx] = 0;
        set_err = (cv[7:1] != 7'h00);
      end
    end
    if (c) begin m_err = 0; m_ovf = 0; end
    if (set_err) m_err = 1;
    if (new_ev) begin
      if (m_uv && !rdy) m_ovf = 1;
      else m_uv = 1;
    end else if (m_uv && rdy) begin
      m_uv = 0;
    end
  endtask

  task automatic compare_all();
    check("digits_out", 32'(digits_out), 32'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}));
    check("dp_out", 32'(dp_out), 32'(m_dp));
    check("valid_out", 32'(valid_out), 32'(m_val));
    check("upd_valid", 32'(bus.upd_valid), 32'(m_uv));
    check("upd_payload", 32'({bus.upd_idx, bus.upd_nibble, bus.upd_dp}), 32'({m_ui, m_un, m_ud}));
    check("err_invalid", 32'(err_invalid), 32'(m_err));
    check("upd_ovf", 32'(upd_ovf), 32'(m_ovf));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (last_vld && bus.upd_ready) dut_acc.push_back(last_pl);
    model_edge(sel_r, seg_r, bus.upd_ready, clr);
    #1;
    compare_all();
    last_vld = bus.upd_valid;
    last_pl  = {bus.upd_idx, bus.upd_nibble, bus.upd_dp};
  endtask

  task automatic hold(input logic [3:0] sel, input logic [7:0] seg, input int n);
    sel_r = sel;
    seg_r = seg;
    repeat (n) cycle();
  endtask

  logic [7:0] scan [4] = '{8'h60, 8'hDA, 8'hF3, 8'h66};

  initial begin
    rst_n = 1'b0; seg_r = '0; sel_r = '0; clr = 1'b0; bus.upd_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    compare_all();

    // 1: single digit capture latency
    sel_r = 4'b0001; seg_r = 8'hFC;
    repeat (6) cycle();
    check("t1_before_edge6", 32'(valid_out), 32'h0);
    cycle();
    check("t1_valid", 32'(valid_out), 32'h1);
    check("t1_digit", 32'(digits_out[3:0]), 32'h0);
    check("t1_upd", 32'({bus.upd_valid, bus.upd_idx, bus.upd_nibble}), 32'({1'b1, 3'd0, 4'd0}));

    // 2: scan of four digits, two passes
    bus.upd_ready = 1'b1;
    repeat (2) cycle();
    dut_acc.delete();
    for (int p = 0; p < 2; p++)
      for (int d = 0; d < 4; d++) hold(4'(1 << d), scan[d], 10);
    check("t2_digits", 32'(digits_out), 32'h4321);
    check("t2_dp", 32'(dp_out), 32'b0100);
    check("t2_nevents", dut_acc.size(), 4);
    for (int k = 0; k < 4; k++)
      check("t2_event", 32'((k < dut_acc.size()) ? dut_acc[k] : 8'hFF),
            32'(ev(k, k + 1, (k == 2) ? 1 : 0)));

    // 3: pattern never stable long enough
    for (int t = 0; t < 8; t++) hold(4'b0001, (t % 2 == 0) ? 8'h60 : 8'hDA, 3);
    check("t3_valid", 32'(valid_out), 32'hF);
    check("t3_digits", 32'(digits_out), 32'h4321);
    check("t3_no_event", 32'(bus.upd_valid), 32'h0);

    // 4: illegal pattern, then clear
    hold(4'b0010, 8'h02, 10);
    check("t4_err", 32'(err_invalid), 32'h1);
    check("t4_valid", 32'(valid_out), 32'b1101);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    check("t4_err_clr", 32'(err_invalid), 32'h0);

    // 5: back-pressure, second event dropped
    bus.upd_ready = 1'b0;
    dut_acc.delete();
    hold(4'b0100, 8'hB6, 10);
    hold(4'b1000, 8'hE4, 10);
    check("t5_held", 32'({bus.upd_valid, bus.upd_idx, bus.upd_nibble}), 32'({1'b1, 3'd2, 4'd5}));
    check("t5_ovf", 32'(upd_ovf), 32'h1);
    bus.upd_ready = 1'b1;
    cycle();
    check("t5_xfer", dut_acc.size(), 1);
    check("t5_xfer_pl", 32'((dut_acc.size() > 0) ? dut_acc[0] : 8'hFF), 32'(ev(2, 5, 0)));
    check("t5_drained", 32'(bus.upd_valid), 32'h0);

    // 6: asynchronous reset mid-settle with an event pending
    bus.upd_ready = 1'b0;
    hold(4'b0001, 8'hFE, 10);
    hold(4'b0010, 8'hF6, 3);
    check("t6_pending", 32'(bus.upd_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_digits", 32'(digits_out), 32'h0);
    check("t6_flags", 32'({dp_out, valid_out, err_invalid, upd_ovf}), 32'h0);
    check("t6_upd", 32'({bus.upd_valid, bus.upd_idx, bus.upd_nibble, bus.upd_dp}), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Random windows of mixed legal, blank, illegal and bad-select patterns
    for (int w = 0; w < 70; w++) begin
      int r, len;
      r = $urandom_range(0, 9);
      if (r == 0) sel_r = 4'b0000;
      else if (r == 1) sel_r = 4'($urandom_range(0, 15));
      else sel_r = 4'(1 << $urandom_range(0, 3));
      r = $urandom_range(0, 9);
      if (r < 7) seg_r = {tab7[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
      else if (r == 7) seg_r = 8'($urandom_range(0, 1));
      else seg_r = 8'($urandom_range(0, 255));
      len = $urandom_range(1, 12);
      for (int c = 0; c < len; c++) begin
        bus.upd_ready = ($urandom_range(0, 3) != 0);
        clr = ($urandom_range(0, 19) == 0);
        cycle();
      end
      clr = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
